// File: rtl/serial_bit_tx_pkg.sv
// Shared frame definitions for the serial transmitter and its consumers:
// FSM state encoding and the line level driven in each part of a frame.
package serial_bit_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b0;
    localparam logic LINE_START = 1'b1;
    localparam logic LINE_STOP  = 1'b0;

    // Frame length in bit periods: start + data + optional parity + stop bits.
    function automatic int frame_bits(input int width, input int parity_en, input int stop_bits);
        return 1 + width + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: tick marks the last cycle of each CLKS_PER_BIT-cycle bit.
// Latency: tick is decoded from the counter register; restart reloads a full period.
module bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clock,
    input  logic reset_b,
    input  logic restart,
    output logic tick
);

    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    assign tick = (count_q == '0);

    // Auto-reload on tick keeps consecutive bits exactly CLKS_PER_BIT cycles long.
    always_comb begin
        count_d = count_q;
        if (restart || tick) begin
            count_d = RELOAD;
        end else begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serial_bit_tx.sv
// Framed serial transmitter: start(1), WIDTH data bits LSB-first, optional even parity, stop(0).
// Word accepted via valid/ready only in IDLE; words offered mid-frame are held off, not dropped.
module serial_bit_tx
    import serial_bit_tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int PARITY_EN    = 1,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(WIDTH - 1);
    localparam logic           LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic           HAS_PARITY = (PARITY_EN != 0);

    tx_state_t        state_q,      state_d;
    logic [WIDTH-1:0] shift_q,      shift_d;
    logic [BCW-1:0]   bit_cnt_q,    bit_cnt_d;
    logic             stop_cnt_q,   stop_cnt_d;
    logic             parity_q,     parity_d;
    logic             serial_out_q, serial_out_d;
    logic             done_q,       done_d;

    logic             tick;
    logic             timer_restart;
    logic [WIDTH-1:0] shifted;

    // Holding the timer in reload while idle makes the start bit a full period from accept.
    assign timer_restart = (state_q == IDLE);
    assign shifted       = shift_q >> 1;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clock   (clock),
        .reset_b (reset_b),
        .restart (timer_restart),
        .tick    (tick)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        parity_d     = parity_q;
        serial_out_d = serial_out_q;
        done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                serial_out_d = LINE_IDLE;
                if (load_valid) begin
                    shift_d      = load_data;
                    parity_d     = ^load_data;
                    bit_cnt_d    = '0;
                    stop_cnt_d   = 1'b0;
                    state_d      = START;
                    serial_out_d = LINE_START;
                end
            end
            START: begin
                if (tick) begin
                    state_d      = DATA;
                    serial_out_d = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        if (HAS_PARITY) begin
                            state_d      = PARITY;
                            serial_out_d = parity_q;
                        end else begin
                            state_d      = STOP;
                            serial_out_d = LINE_STOP;
                        end
                    end else begin
                        shift_d      = shifted;
                        serial_out_d = shifted[0];
                        bit_cnt_d    = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d      = STOP;
                    serial_out_d = LINE_STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d      = IDLE;
                        serial_out_d = LINE_IDLE;
                        done_d       = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d      = IDLE;
                serial_out_d = LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            parity_q     <= 1'b0;
            serial_out_q <= LINE_IDLE;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            parity_q     <= parity_d;
            serial_out_q <= serial_out_d;
            done_q       <= done_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign load_ready = ~busy;
    assign serial_out = serial_out_q;
    assign done       = done_q;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Bench for serial_bit_tx: two configurations (8/par/1stop/1clk and 8/nopar/2stop/3clk)
// compared cycle by cycle against a frame built from the framing rules.
module tb_serial_bit_tx;

    typedef bit frame_q_t[$];

    logic       clock = 1'b0;
    logic       reset_b = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;
    logic       a_rdy, a_so, a_busy, a_done;
    logic       b_rdy, b_so, b_busy, b_done;

    int asserts_n = 0;
    int fails_n   = 0;

    always #5 clock = ~clock;

    serial_bit_tx #(.WIDTH(8), .PARITY_EN(1), .STOP_BITS(1), .CLKS_PER_BIT(1)) dut_a (
        .clock      (clock),
        .reset_b    (reset_b),
        .load_valid (a_valid),
        .load_data  (a_data),
        .load_ready (a_rdy),
        .serial_out (a_so),
        .busy       (a_busy),
        .done       (a_done)
    );

    serial_bit_tx #(.WIDTH(8), .PARITY_EN(0), .STOP_BITS(2), .CLKS_PER_BIT(3)) dut_b (
        .clock      (clock),
        .reset_b    (reset_b),
        .load_valid (b_valid),
        .load_data  (b_data),
        .load_ready (b_rdy),
        .serial_out (b_so),
        .busy       (b_busy),
        .done       (b_done)
    );

    // Reference frame: start=1, data LSB first, even parity (odd ones count -> 1), stops=0.
    function automatic frame_q_t make_frame(input logic [7:0] d, input int par_en, input int stops);
        frame_q_t q;
        q.push_back(1'b1);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (par_en != 0) q.push_back(bit'($countones(d) % 2));
        for (int i = 0; i < stops; i++) q.push_back(1'b0);
        return q;
    endfunction

    task automatic sample(input int sel, output logic so, output logic bz,
                          output logic dn, output logic rd);
        if (sel == 0) begin
            so = a_so; bz = a_busy; dn = a_done; rd = a_rdy;
        end else begin
            so = b_so; bz = b_busy; dn = b_done; rd = b_rdy;
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        if (sel == 0) begin
            a_valid = v; a_data = d;
        end else begin
            b_valid = v; b_data = d;
        end
    endtask

    task automatic test_reset;
        logic so, bz, dn, rd;
        reset_b = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_b = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            for (int s = 0; s < 2; s++) begin
                sample(s, so, bz, dn, rd);
                asserts_n++;
                if (so !== 1'b0 || bz !== 1'b0 || dn !== 1'b0 || rd !== 1'b1) begin
                    fails_n++;
                    $display("FAIL reset dut%0d cycle %0d: so/busy/done/rdy=%b%b%b%b want 0001",
                             s, k, so, bz, dn, rd);
                end
            end
        end
    endtask

    task automatic test_frame_a5;
        logic so, bz, dn, rd;
        logic [0:10] exp_seq;
        exp_seq = 11'b11010010100;
        @(posedge clock);
        #1 drive(0, 1'b1, 8'hA5);
        asserts_n++;
        if (a_rdy !== 1'b1) begin
            fails_n++;
            $display("FAIL a5_ready: got %b want 1", a_rdy);
        end
        @(posedge clock);
        #1 drive(0, 1'b0, 8'($urandom));
        for (int k = 1; k <= 13; k++) begin
            @(negedge clock);
            sample(0, so, bz, dn, rd);
            asserts_n++;
            if (k <= 11) begin
                if (so !== exp_seq[k-1] || bz !== 1'b1 || dn !== 1'b0) begin
                    fails_n++;
                    $display("FAIL a5_frame cycle %0d: so/busy/done=%b%b%b want %b10",
                             k, so, bz, dn, exp_seq[k-1]);
                end
            end else begin
                if (so !== 1'b0 || bz !== 1'b0 || dn !== (k == 12) || rd !== 1'b1) begin
                    fails_n++;
                    $display("FAIL a5_end cycle %0d: so/busy/done/rdy=%b%b%b%b want 00%b1",
                             k, so, bz, dn, rd, k == 12);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic so, bz, dn, rd;
        frame_q_t f1, f2;
        logic exp_so, exp_bz, exp_dn;
        f1 = make_frame(8'h01, 1, 1);
        f2 = make_frame(8'hFF, 1, 1);
        @(posedge clock);
        #1 drive(0, 1'b1, 8'h01);
        @(posedge clock);
        #1 drive(0, 1'b1, 8'hFF);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clock);
            sample(0, so, bz, dn, rd);
            if (k <= 11) begin
                exp_so = f1[k-1]; exp_bz = 1'b1; exp_dn = 1'b0;
            end else if (k == 12 || k == 24) begin
                exp_so = 1'b0; exp_bz = 1'b0; exp_dn = 1'b1;
            end else begin
                exp_so = f2[k-13]; exp_bz = 1'b1; exp_dn = 1'b0;
            end
            asserts_n++;
            if (so !== exp_so || bz !== exp_bz || dn !== exp_dn) begin
                fails_n++;
                $display("FAIL b2b cycle %0d: so/busy/done=%b%b%b want %b%b%b",
                         k, so, bz, dn, exp_so, exp_bz, exp_dn);
            end
            if (k == 13) drive(0, 1'b0, 8'h00);
        end
        @(negedge clock);
    endtask

    task automatic test_slow_frame;
        logic so, bz, dn, rd;
        frame_q_t f;
        f = make_frame(8'h80, 0, 2);
        @(posedge clock);
        #1 drive(1, 1'b1, 8'h80);
        @(posedge clock);
        #1 drive(1, 1'b0, 8'h55);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clock);
            sample(1, so, bz, dn, rd);
            asserts_n++;
            if (k <= 33) begin
                if (so !== f[(k-1)/3] || bz !== 1'b1 || dn !== 1'b0) begin
                    fails_n++;
                    $display("FAIL slow_frame cycle %0d: so/busy/done=%b%b%b want %b10",
                             k, so, bz, dn, f[(k-1)/3]);
                end
            end else if (dn !== 1'b1 || bz !== 1'b0 || so !== 1'b0) begin
                fails_n++;
                $display("FAIL slow_done: so/busy/done=%b%b%b want 001", so, bz, dn);
            end
            if (k >= 25 && k <= 27) begin
                asserts_n++;
                if (so !== 1'b1) begin
                    fails_n++;
                    $display("FAIL slow_bit7 cycle %0d: got %b want 1", k, so);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic so, bz, dn, rd;
        frame_q_t f;
        @(posedge clock);
        #1 drive(0, 1'b1, 8'hFF);
        @(posedge clock);
        #1 drive(0, 1'b0, 8'h00);
        repeat (5) @(negedge clock);
        #1 reset_b = 1'b0;
        #1 sample(0, so, bz, dn, rd);
        asserts_n++;
        if (so !== 1'b0 || bz !== 1'b0 || rd !== 1'b1 || dn !== 1'b0) begin
            fails_n++;
            $display("FAIL midreset: so/busy/done/rdy=%b%b%b%b want 0001", so, bz, dn, rd);
        end
        @(posedge clock);
        #1 reset_b = 1'b1;
        f = make_frame(8'h3C, 1, 1);
        @(posedge clock);
        #1 drive(0, 1'b1, 8'h3C);
        @(posedge clock);
        #1 drive(0, 1'b0, 8'h00);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            sample(0, so, bz, dn, rd);
            asserts_n++;
            if (k <= 11 ? (so !== f[k-1] || bz !== 1'b1 || dn !== 1'b0)
                        : (so !== 1'b0 || bz !== 1'b0 || dn !== 1'b1)) begin
                fails_n++;
                $display("FAIL post_reset_frame cycle %0d: so/busy/done=%b%b%b", k, so, bz, dn);
            end
        end
    endtask

    task automatic test_random;
        logic so, bz, dn, rd;
        logic exp_so;
        frame_q_t f;
        logic [7:0] d;
        int sel, cpb, flen;
        for (int i = 0; i < 8; i++) begin
            sel = i % 2;
            d   = 8'($urandom);
            cpb = (sel == 0) ? 1 : 3;
            f   = (sel == 0) ? make_frame(d, 1, 1) : make_frame(d, 0, 2);
            flen = f.size() * cpb;
            @(posedge clock);
            #1 drive(sel, 1'b1, d);
            @(posedge clock);
            #1 drive(sel, 1'b0, 8'($urandom));
            for (int k = 1; k <= flen + 1; k++) begin
                @(negedge clock);
                sample(sel, so, bz, dn, rd);
                exp_so = (k <= flen) ? f[(k-1)/cpb] : 1'b0;
                asserts_n++;
                if (so !== exp_so || bz !== (k <= flen) || dn !== (k == flen + 1)) begin
                    fails_n++;
                    $display("FAIL random dut%0d data %h cycle %0d: so/busy/done=%b%b%b want %b%b%b",
                             sel, d, k, so, bz, dn, exp_so, k <= flen, k == flen + 1);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_frame_a5();
        test_back_to_back();
        test_slow_frame();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts_n, fails_n);
        $finish;
    end

endmodule
